led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
Parametrised LED pattern generator: the successor to the fixed 8-bit single-rotation LED driver. A programmable prescaler produces step ticks. On each tick the LED register advances by one of four patterns: rotate, bounce, binary count, or Johnson fill. A tick counter and a pattern-wrap pulse are provided for board status and debug. The block sits directly behind board LED pins and is clocked by the system clock.

Parameters:
WIDTH, 8, LED/pattern width; legal range is 2 or more.
DIV_W, 16, prescaler divisor and counter width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  prescaler enable; 0 freezes the prescaler and all pattern state
mode  input  2  pattern select: 0 ROTATE, 1 BOUNCE, 2 COUNT, 3 FILL
dir  input  1  direction: 0 left/up, 1 right/down; ignored in BOUNCE
div  input  DIV_W  a tick occurs every div+1 enabled cycles
led  output  WIDTH  pattern register
tick  output  1  one-cycle pulse, coincident with each led update
wrap  output  1  one-cycle pulse when the pattern returns to its seed
step_cnt  output  WIDTH  tick counter, modulo 2^WIDTH

Behaviour:
- Reset: one clock domain, clk; rst is asynchronous and active-high. On reset:
  - led = seed(ROTATE), i.e. only the MSB set (8'h80 at WIDTH=8)
  - step_cnt = 0, tick = 0, wrap = 0
  - prescaler count = 0, registered mode mode_q = 0, bounce direction = down (toward LSB)
- Seeds: ROTATE = MSB only; BOUNCE = MSB only; COUNT = all zero; FILL = all zero.
- Prescaler:
  - When en=1, if pcnt >= div then tick_int=1 and pcnt resets to 0; otherwise pcnt increments.
  - The >= compare makes a div lowered below the current pcnt produce a tick on the next enabled cycle.
  - div=0 gives a tick every enabled cycle.
  - When en=0, pcnt and all outputs hold; tick and wrap are 0.
- Mode change: when mode != mode_q, on that clock edge:
  - mode_q <= mode, led <= seed(mode)
  - pcnt <= 0, step_cnt <= 0, bounce direction <= down
  - tick = 0, wrap = 0
  - This takes priority over any tick that would occur in the same cycle. It applies regardless of en.
- Tick timing: on a tick edge, led takes its next value, step_cnt increments, and tick is registered high for exactly that following cycle. Latency from the terminal pcnt cycle to the led change is one edge.
- Pattern advance per tick:
  - ROTATE:
    - dir=0: led <= {led[W-2:0], led[W-1]}
    - dir=1: led <= {led[0], led[W-1:1]}
  - BOUNCE:
    - Single hot bit; moves toward the LSB while the direction is down, toward the MSB while up.
    - At the LSB the direction flips to up; at the MSB it flips to down.
    - The flip and the move happen on the same tick, so the bit never dwells twice at an end.
    - Period is 2*(WIDTH-1) ticks.
  - COUNT: dir=0 gives led+1 and dir=1 gives led-1, both modulo 2^WIDTH.
  - FILL (Johnson):
    - dir=0: led <= {led[W-2:0], ~led[W-1]}
    - dir=1: led <= {~led[0], led[W-1:1]}
    - Period is 2*WIDTH ticks.
- wrap: asserted with a tick when the new led value equals seed(mode_q).
- dir changes take effect on the next tick. No reload occurs.
- Reset asserted mid-operation forces the reset values immediately, independent of clk. Operation resumes at the first clk edge after deassertion, from pcnt=0.
- Illegal states: none; all 2-bit mode values are defined.

Test Plan:
1. Reset/idle: assert rst with clk running and mode=0 -> led=8'h80, step_cnt=0, tick=0, wrap=0. Release rst with en=0 -> outputs hold for 20 cycles.
2. ROTATE with mode=0, dir=0, div=3, en=1:
   - tick every 4th cycle; led sequence 80,01,02,04,...,40,80
   - wrap coincides with the 8th tick; step_cnt=8 afterwards
   - repeat with dir=1 -> 80,40,...,01,80
3. BOUNCE with mode=1, div=0:
   - after the reload cycle: 80,40,20,10,08,04,02,01,02,04,...,40,80
   - wrap on the 14th tick; tick high every cycle
4. COUNT and FILL with div=0:
   - mode=2, dir=1 from seed 00 -> FF,FE,...; wrap on the 256th tick when led=00
   - mode=3, dir=0 -> 01,03,07,...,FF,FE,FC,...,80,00; wrap on the 16th tick
5. Prescaler edges:
   - div=100: drop en at pcnt=50 for 10 cycles -> no tick, led/pcnt frozen; resume -> tick 50 enabled cycles later
   - set div=10 while pcnt=50 -> tick on the next enabled cycle
6. Mode change and reset mid-run:
   - switch mode 0->2 on the same cycle a tick is due -> led=00, step_cnt=0, tick=0, next tick div+1 cycles later
   - pulse rst between clk edges -> led=80 immediately, before the next edge

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator (rotate, bounce, binary count, Johnson fill)
// with a step counter and a wrap pulse when the pattern returns to its seed.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap,
    output logic [WIDTH-1:0] step_cnt
);
    typedef enum logic [1:0] {ROTATE, BOUNCE, COUNT, FILL} mode_e;

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] seed(input mode_e m);
        return (m == ROTATE || m == BOUNCE) ? MSB : '0;
    endfunction

    mode_e            mode_q, mode_d;
    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] led_q, led_d, step_q, step_d;
    logic             tick_q, tick_d, wrap_q, wrap_d, up_q, up_d;
    logic             mode_chg, go, turn, up_n;
    logic [WIDTH-1:0] rot, bnc, cnt, fil, adv;

    always_comb begin
        mode_d   = mode_e'(mode);
        mode_chg = mode_d != mode_q;
        go       = en && (pcnt_q >= div) && !mode_chg;
        rot      = dir ? {led_q[0], led_q[WIDTH-1:1]} : {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        // The bounce turns around on the same tick it reaches an end, so no dwell.
        turn     = up_q ? led_q[WIDTH-1] : led_q[0];
        up_n     = up_q ^ turn;
        bnc      = up_n ? led_q << 1 : led_q >> 1;
        cnt      = dir ? led_q - WIDTH'(1) : led_q + WIDTH'(1);
        fil      = dir ? {~led_q[0], led_q[WIDTH-1:1]} : {led_q[WIDTH-2:0], ~led_q[WIDTH-1]};
        adv      = mode_q == ROTATE ? rot : mode_q == BOUNCE ? bnc : mode_q == COUNT ? cnt : fil;
        pcnt_d   = mode_chg ? '0 : !en ? pcnt_q : (pcnt_q >= div) ? '0 : pcnt_q + DIV_W'(1);
        led_d    = mode_chg ? seed(mode_d) : go ? adv : led_q;
        step_d   = mode_chg ? '0 : go ? step_q + WIDTH'(1) : step_q;
        up_d     = mode_chg ? 1'b0 : (go && mode_q == BOUNCE) ? up_n : up_q;
        tick_d   = go;
        wrap_d   = go && (adv == seed(mode_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= ROTATE;
            pcnt_q <= '0;
            led_q  <= MSB;
            step_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            up_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pcnt_q <= pcnt_d;
            led_q  <= led_d;
            step_q <= step_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            up_q   <= up_d;
        end
    end

    assign led      = led_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign step_cnt = step_q;
endmodule
